// File: rtl/stream_demux_1_n.sv
// Registered 1-to-N packet demultiplexer: a select is locked on the first beat and each output has a one-entry register.
// Optional macro STREAM_DEMUX_ERR_CNT_EN adds a saturating 16-bit err_cnt of packets dropped for an illegal select.
module stream_demux_1_n #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 4,
    parameter int SEL_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_last,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]        out_last,
    output logic                    sel_err
`ifdef STREAM_DEMUX_ERR_CNT_EN
    ,
    output logic [15:0]             err_cnt
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FWD  = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    localparam logic [SEL_W:0] N_OUT_W = (SEL_W+1)'(N_OUT);

    logic [1:0]              state_q, state_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [N_OUT-1:0]        out_valid_q, out_valid_d;
    logic [N_OUT*DATA_W-1:0] out_data_q, out_data_d;
    logic [N_OUT-1:0]        out_last_q, out_last_d;
    logic                    sel_err_q, sel_err_d;

    logic [N_OUT-1:0] can_wr;
    logic [N_OUT-1:0] wr_en;
    logic [SEL_W-1:0] cur_sel;
    logic             sel_legal;
    logic             sel_ready;
    logic             accept;

    assign can_wr = ~out_valid_q | out_ready;

    // In IDLE the live select steers the beat; afterwards the locked one does.
    always_comb begin
        cur_sel   = (state_q == IDLE) ? in_sel : sel_q;
        sel_legal = ({1'b0, cur_sel} < N_OUT_W);
        sel_ready = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (cur_sel == SEL_W'(k)) begin
                sel_ready = can_wr[k];
            end
        end
        in_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE:    in_ready = sel_legal ? sel_ready : 1'b1;
                FWD:     in_ready = sel_ready;
                DROP:    in_ready = 1'b1;
                default: in_ready = 1'b0;
            endcase
        end
        accept = in_valid && in_ready;
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        sel_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (sel_legal) begin
                        sel_d   = in_sel;
                        state_d = in_last ? IDLE : FWD;
                    end else begin
                        sel_err_d = 1'b1;
                        state_d   = in_last ? IDLE : DROP;
                    end
                end
            end
            FWD, DROP: begin
                if (accept && in_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A write and a drain in the same cycle keep valid high for full throughput.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        wr_en       = '0;
        for (int k = 0; k < N_OUT; k++) begin
            wr_en[k] = accept && sel_legal && (state_q != DROP) && (cur_sel == SEL_W'(k));
            if (wr_en[k]) begin
                out_valid_d[k]                = 1'b1;
                out_data_d[k*DATA_W +: DATA_W] = in_data;
                out_last_d[k]                 = in_last;
            end else if (out_ready[k]) begin
                out_valid_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            out_valid_q <= '0;
            out_data_q  <= '0;
            out_last_q  <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            sel_err_q   <= sel_err_d;
        end
    end

`ifdef STREAM_DEMUX_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (sel_err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_stream_demux_1_n.sv
// Scoreboard testbench for stream_demux_1_n: accepted beats are queued per destination and matched as they leave.
// Build with STREAM_DEMUX_ERR_CNT_EN defined to also exercise err_cnt and its saturation.
module tb_stream_demux_1_n;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int SW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            in_last;
    logic [SW-1:0]   in_sel;
    logic [N-1:0]    out_valid;
    logic [N-1:0]    out_ready;
    logic [N*DW-1:0] out_data;
    logic [N-1:0]    out_last;
    logic            sel_err;
`ifdef STREAM_DEMUX_ERR_CNT_EN
    logic [15:0]     err_cnt;
    int              exp_cnt;
`endif

    always #5 clk = ~clk;

    stream_demux_1_n #(.DATA_W(DW), .N_OUT(N), .SEL_W(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .sel_err   (sel_err)
`ifdef STREAM_DEMUX_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            ch;
        int            cyc;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    cur_dest = 0;
    bit    first_beat = 1'b1;
    bit    exp_err = 1'b0;
    bit    lat_chk = 1'b0;
    logic          obs_ready;
    logic [N-1:0]  obs_valid;
    logic [N*DW-1:0] obs_data;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int findBeat(input int ch);
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].ch == ch) return i;
        end
        return -1;
    endfunction

    // One clock cycle: drive at the falling edge, observe just before the rising edge.
    task automatic applyStimulus(input logic v, input logic [SW-1:0] sel, input logic [DW-1:0] d,
                                 input logic l, input logic [N-1:0] rdy);
        int  idx;
        bit  next_err;
        @(negedge clk);
        in_valid  = v;
        in_sel    = sel;
        in_data   = d;
        in_last   = l;
        out_ready = rdy;
        #4;
        obs_ready = in_ready;
        obs_valid = out_valid;
        obs_data  = out_data;
        checkOutput("sel_err", 32'(sel_err), 32'(exp_err));
`ifdef STREAM_DEMUX_ERR_CNT_EN
        checkOutput("err_cnt", 32'(err_cnt), 32'(exp_cnt));
`endif
        for (int k = 0; k < N; k++) begin
            idx = findBeat(k);
            checkOutput($sformatf("out_valid%0d", k), 32'(out_valid[k]), 32'(idx >= 0));
            if (out_valid[k] && idx >= 0) begin
                checkOutput($sformatf("out_data%0d", k), 32'(out_data[k*DW +: DW]), 32'(sb[idx].data));
                checkOutput($sformatf("out_last%0d", k), 32'(out_last[k]), 32'(sb[idx].last));
                if (out_ready[k]) begin
                    if (lat_chk) checkOutput("latency", 32'(cyc - sb[idx].cyc), 32'd1);
                    sb.delete(idx);
                end
            end
        end
        next_err = 1'b0;
        if (v && in_ready) begin
            if (first_beat) cur_dest = int'(sel);
            if (cur_dest < N) begin
                sb.push_back('{data: d, last: l, ch: cur_dest, cyc: cyc});
            end else if (first_beat) begin
                next_err = 1'b1;
`ifdef STREAM_DEMUX_ERR_CNT_EN
                if (exp_cnt != 32'hFFFF) exp_cnt++;
`endif
            end
            first_beat = l;
        end
        exp_err = next_err;
        cyc++;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        #4;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
        #4;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_last", 32'(out_last), 32'd0);
        checkOutput("rst_sel_err", 32'(sel_err), 32'd0);
`ifdef STREAM_DEMUX_ERR_CNT_EN
        checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
        exp_cnt = 0;
`endif
        cyc++;
        sb.delete();
        first_beat = 1'b1;
        exp_err    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; in_last = 1'b0; out_ready = '1;
        resetDut();

        $display("[TB] single-beat routing");
        applyStimulus(1'b1, 4'd2, 8'hA5, 1'b1, 4'hF);
        checkOutput("t1_ready", 32'(obs_ready), 32'd1);
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'hF);
        checkOutput("t1_valid", 32'(obs_valid), 32'h4);
        checkOutput("t1_data", 32'(obs_data[2*DW +: DW]), 32'hA5);
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'hF);
        checkOutput("t1_valid_clr", 32'(obs_valid), 32'h0);

        $display("[TB] select locking");
        applyStimulus(1'b1, 4'd1, 8'h11, 1'b0, 4'hF);
        applyStimulus(1'b1, 4'd3, 8'h22, 1'b0, 4'hF);
        applyStimulus(1'b1, 4'd3, 8'h33, 1'b1, 4'hF);
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'hF);
        checkOutput("t2_valid", 32'(obs_valid), 32'h2);
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'hF);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 4'd0, 8'hC1, 1'b1, 4'hE);
        checkOutput("t3_ready1", 32'(obs_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'd0, 8'hC2, 1'b1, 4'hE);
            checkOutput("t3_ready2_blocked", 32'(obs_ready), 32'd0);
            checkOutput("t3_hold", 32'(obs_data[DW-1:0]), 32'hC1);
        end
        applyStimulus(1'b1, 4'd0, 8'hC2, 1'b1, 4'hF);
        checkOutput("t3_ready2", 32'(obs_ready), 32'd1);
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'hF);
        checkOutput("t3_second", 32'(obs_data[DW-1:0]), 32'hC2);
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'hF);

        $display("[TB] illegal select");
        applyStimulus(1'b1, 4'd5, 8'hE1, 1'b0, 4'hF);
        checkOutput("t4_ready1", 32'(obs_ready), 32'd1);
        applyStimulus(1'b1, 4'd5, 8'hE2, 1'b1, 4'hF);
        checkOutput("t4_ready2", 32'(obs_ready), 32'd1);
        applyStimulus(1'b1, 4'hF, 8'hE3, 1'b1, 4'hF);
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'hF);
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'hF);
        checkOutput("t4_no_valid", 32'(obs_valid), 32'h0);

        $display("[TB] reset mid-packet");
        applyStimulus(1'b1, 4'd3, 8'h31, 1'b0, 4'h7);
        resetDut();
        applyStimulus(1'b1, 4'd0, 8'h5A, 1'b1, 4'hF);
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'hF);
        checkOutput("t5_valid", 32'(obs_valid), 32'h1);
        checkOutput("t5_data", 32'(obs_data[DW-1:0]), 32'h5A);

        $display("[TB] back-to-back throughput");
        lat_chk = 1'b1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, SW'(i % 2), 8'(8'h40 + i), 1'b1, 4'hF);
            checkOutput("t6_ready", 32'(obs_ready), 32'd1);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, SW'(i % 2), 8'(8'h60 + i), 1'(i % 2), 4'hF);
            checkOutput("t6_multi_ready", 32'(obs_ready), 32'd1);
        end
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'hF);
        lat_chk = 1'b0;

        $display("[TB] random traffic");
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), SW'($urandom_range(0, 5)), 8'($urandom),
                          1'($urandom_range(0, 2) == 0), 4'($urandom));
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'hF);

`ifdef STREAM_DEMUX_ERR_CNT_EN
        $display("[TB] err_cnt saturation");
        resetDut();
        for (int i = 0; i < 65540; i++) begin
            applyStimulus(1'b1, 4'd9, 8'h00, 1'b1, 4'hF);
        end
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'hF);
        checkOutput("err_cnt_sat", 32'(err_cnt), 32'hFFFF);
`endif

        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_demux_1_n.md
Name: stream_demux_1_n

Overview:
- Parametrised, registered 1-to-N packet demultiplexer with valid/ready handshakes. It is the successor to the combinational 1:4 demux.
- One input stream is routed to one of N_OUT output channels. The channel is chosen by a select that is sampled on the first beat of a packet and held until the last beat.
- Each output has a single-entry output register.
- Sits between a shared producer (for example an RX parser) and per-channel consumers.

Parameters:
- DATA_W, 8, data width per beat.
- N_OUT, 4, number of output channels; legal range 2..16.
- SEL_W, 4, width of in_sel. Must satisfy 2**SEL_W >= N_OUT. Select values >= N_OUT are illegal.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  DATA_W  input beat data.
- in_last  input  1  final beat of the packet.
- in_sel  input  SEL_W  destination channel; sampled only on the first beat of a packet.
- out_valid  output  N_OUT  per-channel valid.
- out_ready  input  N_OUT  per-channel ready.
- out_data  output  N_OUT*DATA_W  per-channel data; channel k occupies bits [k*DATA_W +: DATA_W].
- out_last  output  N_OUT  per-channel last flag.
- sel_err  output  1  one-cycle pulse when a packet with an illegal select is accepted.

Behaviour:
- Reset values:
  - out_valid = 0, out_data = 0, out_last = 0, sel_err = 0.
  - FSM goes to IDLE; locked select = 0.
  - in_ready is forced to 0 while rst = 1.
- Channel k accepts a write when can_wr[k] = !out_valid[k] || out_ready[k]. The combinational ready pass-through is permitted.
- FSM states:
  - IDLE:
    - If in_sel < N_OUT: in_ready = can_wr[in_sel]. On accept, write the beat to channel in_sel and lock the select. If !in_last, go to FWD; otherwise stay in IDLE.
    - If in_sel >= N_OUT: in_ready = 1 and the beat is discarded. sel_err pulses on the next cycle. If !in_last, go to DROP.
  - FWD:
    - in_ready = can_wr[locked select]; in_sel is ignored.
    - Each accepted beat is written to the locked channel.
    - An accepted in_last returns the FSM to IDLE.
  - DROP:
    - in_ready = 1; all beats are discarded.
    - An accepted in_last returns the FSM to IDLE. No further sel_err pulse.
- Output register, channel k:
  - On a write: out_valid[k] <= 1 and out_data/out_last are loaded. This happens on the cycle after the input accept (latency 1).
  - Simultaneous drain (out_valid[k] && out_ready[k]) and write: new data is loaded and valid stays 1, giving full throughput of 1 beat/cycle.
  - Drain without a write: out_valid[k] <= 0; data is held.
  - While out_valid[k] = 1 && out_ready[k] = 0: out_data[k] and out_last[k] must stay stable.
- Only the locked/selected channel is ever written. The other channels keep draining independently.
- Back-to-back packets: a last beat accepted in IDLE or FWD lets the next cycle sample a new in_sel. There is no bubble.
- Single-beat packets (in_last on the first beat) never leave IDLE.
- Reset mid-packet: all buffered beats are lost, valids clear, and the FSM returns to IDLE. The next accepted beat is treated as a packet start.
- in_valid low while in FWD or DROP: the state and locked select are held indefinitely.

Optional Feature:
- Macro: STREAM_DEMUX_ERR_CNT_EN.
- Defined:
  - Adds output port err_cnt, 16 bits: a count of packets dropped for an illegal select.
  - It increments in the same cycle sel_err is asserted and saturates at 16'hFFFF.
  - It resets to 0 on rst.
- Not defined:
  - The port and the counter do not exist.
  - sel_err behaviour is unchanged.

Test Plan:
1. Single-beat routing. With rst deasserted and all out_ready = 1, send in_sel = 2, in_data = 8'hA5, in_last = 1. Required: one cycle later out_valid = 4'b0100 and channel 2 data = 8'hA5 with out_last[2] = 1. The next cycle out_valid = 0.
2. Select locking. Send a 3-beat packet (8'h11, 8'h22, 8'h33) with in_sel = 1 on the first beat, then change in_sel to 3 on beats 2 and 3. Required: all three beats appear on channel 1 only, with out_last[1] only on 8'h33.
3. Backpressure. Hold out_ready[0] = 0 and send two beats to channel 0. Required:
   - The first beat is accepted and out_valid[0] = 1.
   - in_ready = 0 for the second beat, and channel 0 data stays stable.
   - Raising out_ready[0] accepts the second beat in the same cycle; it appears on the following cycle.
4. Illegal select. With N_OUT = 4 and SEL_W = 3, send a 2-beat packet with in_sel = 5. Required:
   - in_ready = 1 on both beats.
   - No out_valid is asserted.
   - sel_err pulses once.
   - With STREAM_DEMUX_ERR_CNT_EN defined, err_cnt goes 0 -> 1. Saturation check: preload to 16'hFFFF by driving 65535 or more illegal packets, and require err_cnt to stay at 16'hFFFF.
5. Reset mid-packet. Send beat 1 of a 3-beat packet to channel 3 with out_ready[3] = 0, then assert rst for 1 cycle. Required:
   - out_valid = 0 and out_data = 0.
   - The next beat with in_sel = 0, in_last = 1 is routed to channel 0.
6. Back-to-back throughput. Drive a continuous stream of packets alternating channel 0 and channel 1, each 1 beat, with all out_ready = 1. Required: in_ready stays 1 every cycle and each beat exits exactly 1 cycle after it is accepted.
